alu_lanes_pipe: RTL and testbench



---
 rtl/alu_lanes_pkg.sv | 20 ++
 rtl/alu_lanes_pipe_lane.sv | 70 +++++++
 rtl/alu_lanes_pipe.sv | 87 ++++++++
 tb/tb_alu_lanes_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_lanes_pkg.sv
// Shared types and constants for the pipelined SIMD vector ALU.
package alu_lanes_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MOV  = 3'b010,
    ALU_MUL  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_MULH = 3'b111
  } alu_op_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_lanes_pipe_lane.sv
// Combinational single-lane datapath: result and {N,Z,C,V} for one W-bit lane.
module alu_lane
  import alu_lanes_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  input  logic         sat_en,
  input  logic         en,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   raw;
  logic           c;
  logic           v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = (2*W)'(a) * (2*W)'(b);

  always_comb begin
    raw = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ALU_ADD: begin
        raw = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        raw = diff[W-1:0];
        c   = ~diff[W];
        v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_MOV:  raw = b;
      ALU_MUL: begin
        raw = prod[W-1:0];
        c   = |prod[2*W-1:W];
      end
      ALU_AND:  raw = a & b;
      ALU_OR:   raw = a | b;
      ALU_XOR:  raw = a ^ b;
      ALU_MULH: raw = prod[2*W-1:W];
    endcase

    // v is only ever set for ADD/SUB; overflow direction follows the sign of a
    res = raw;
    if (sat_en && v)
      res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    flags         = '0;
    flags[FLAG_N] = res[W-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;

    if (!en) begin
      res   = a;
      flags = '0;
    end
  end

endmodule

// File: rtl/alu_lanes_pipe.sv
// Two-stage valid/ready pipelined SIMD ALU: S1 holds operands, S2 holds results.
module alu_lanes_pipe
  import alu_lanes_pkg::*;
#(
  parameter int unsigned LANES = 6,
  parameter int unsigned W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] src_a,
  input  logic [LANES*W-1:0] src_b,
  input  logic [2:0]         alu_control,
  input  logic               sat_en,
  input  logic [LANES-1:0]   lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] result,
  output logic [LANES*4-1:0] flags
);

  logic               s1_valid;
  logic [LANES*W-1:0] s1_a;
  logic [LANES*W-1:0] s1_b;
  alu_op_t            s1_op;
  logic               s1_sat;
  logic [LANES-1:0]   s1_en;
  logic               s2_valid;
  logic               s1_load;
  logic               s2_load;
  logic [LANES*W-1:0] next_result;
  logic [LANES*4-1:0] next_flags;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ALU_ADD;
      s1_sat   <= 1'b0;
      s1_en    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= src_a;
        s1_b   <= src_b;
        s1_op  <= alu_op_t'(alu_control);
        s1_sat <= sat_en;
        s1_en  <= lane_en;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane #(.W(W)) u_lane (
      .a      (s1_a[i*W +: W]),
      .b      (s1_b[i*W +: W]),
      .op     (s1_op),
      .sat_en (s1_sat),
      .en     (s1_en[i]),
      .res    (next_result[i*W +: W]),
      .flags  (next_flags[i*4 +: 4])
    );
  end

  // result/flags only update on a real op, so they stay put under stall and bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= next_result;
        flags  <= next_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_lanes_pipe.sv
// Directed self-checking bench for alu_lanes_pipe (LANES=6, W=8).
module tb_alu_lanes_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] src_a;
  logic [47:0] src_b;
  logic [2:0]  alu_control;
  logic        sat_en;
  logic [5:0]  lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] result;
  logic [23:0] flags;

  int total = 0;
  int bad   = 0;

  alu_lanes_pipe #(.LANES(6), .W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .sat_en      (sat_en),
    .lane_en     (lane_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op with out_ready high; return one cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [47:0] a, input logic [47:0] b,
                       input logic sat, input logic [5:0] en);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    sat_en      = sat;
    lane_en     = en;
    in_valid    = 1'b1;
    check("in_ready_before_accept", 48'(in_ready), 48'd1);
    tick();
    in_valid = 1'b0;
    check("out_valid_latency0", 48'(out_valid), 48'd0);
    tick();
    check("out_valid_latency1", 48'(out_valid), 48'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    src_a       = '0;
    src_b       = '0;
    alu_control = 3'b000;
    sat_en      = 1'b0;
    lane_en     = 6'b111111;
    out_ready   = 1'b1;
    tick();
    tick();
    check("reset_out_valid", 48'(out_valid), 48'd0);
    check("reset_result", result, 48'h0);
    check("reset_flags", 48'(flags), 48'h0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 48'(in_ready), 48'd1);

    // ADD basic
    issue(3'b000, 48'h01, 48'h0A, 1'b0, 6'b111111);
    check("add_result", result, 48'h0B);
    check("add_flags", 48'(flags), 48'h444440);

    // ADD carry out of lane0 must not reach lane1
    issue(3'b000, 48'h01FF, 48'h0001, 1'b0, 6'b111111);
    check("add_carry_result", result, 48'h0100);
    check("add_carry_flags", 48'(flags), 48'h444406);

    // SUB
    issue(3'b001, 48'h050A, 48'h0A05, 1'b0, 6'b111111);
    check("sub_result", result, 48'hFB05);
    check("sub_flags", 48'(flags), 48'h666682);

    // Saturation boundaries
    issue(3'b000, 48'h7F, 48'h01, 1'b1, 6'b111111);
    check("add_sat_result", result, 48'h7F);
    check("add_sat_flags", 48'(flags), 48'h444441);
    issue(3'b000, 48'h7F, 48'h01, 1'b0, 6'b111111);
    check("add_wrap_result", result, 48'h80);
    check("add_wrap_flags", 48'(flags), 48'h444449);
    issue(3'b001, 48'h80, 48'h01, 1'b1, 6'b111111);
    check("sub_sat_result", result, 48'h80);
    check("sub_sat_flags", 48'(flags), 48'h66666B);

    // Multiply
    issue(3'b011, 48'h05, 48'h05, 1'b0, 6'b111111);
    check("mul_result", result, 48'h19);
    check("mul_flags", 48'(flags), 48'h444440);
    issue(3'b011, 48'h10, 48'h10, 1'b0, 6'b111111);
    check("mul_ovf_result", result, 48'h00);
    check("mul_ovf_flags", 48'(flags), 48'h444446);
    issue(3'b111, 48'h10, 48'h10, 1'b0, 6'b111111);
    check("mulh_result", result, 48'h01);
    check("mulh_flags", 48'(flags), 48'h444440);

    // XOR
    issue(3'b110, 48'hAAF0, 48'hAAFF, 1'b0, 6'b111111);
    check("xor_result", result, 48'h0F);
    check("xor_flags", 48'(flags), 48'h444440);

    // MOV with only lane0 enabled; disabled lanes pass src_a through
    issue(3'b010, 48'h0000_2200_0000, 48'h0B, 1'b0, 6'b000001);
    check("mov_lane_en_result", result, 48'h0000_2200_000B);
    check("mov_lane_en_flags", 48'(flags), 48'h0);

    // Backpressure: four ADDs, lane0 = (1..4) + 0x10
    tick();
    out_ready   = 1'b0;
    alu_control = 3'b000;
    sat_en      = 1'b0;
    lane_en     = 6'b111111;
    src_b       = 48'h10;
    src_a       = 48'h01;
    in_valid    = 1'b1;
    check("bp_ready0", 48'(in_ready), 48'd1);
    tick();
    src_a = 48'h02;
    check("bp_ready1", 48'(in_ready), 48'd1);
    tick();
    src_a = 48'h03;
    check("bp_valid", 48'(out_valid), 48'd1);
    check("bp_full_ready", 48'(in_ready), 48'd0);
    check("bp_res0", result, 48'h11);
    tick();
    check("bp_hold_ready", 48'(in_ready), 48'd0);
    check("bp_hold_res", result, 48'h11);
    tick();
    check("bp_hold_res2", result, 48'h11);
    check("bp_hold_valid", 48'(out_valid), 48'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 48'(in_ready), 48'd1);
    tick();
    src_a = 48'h04;
    check("bp_res1", result, 48'h12);
    check("bp_res1_valid", 48'(out_valid), 48'd1);
    tick();
    in_valid = 1'b0;
    check("bp_res2", result, 48'h13);
    tick();
    check("bp_res3", result, 48'h14);
    check("bp_res3_valid", 48'(out_valid), 48'd1);
    tick();
    check("bp_drained", 48'(out_valid), 48'd0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    src_a     = 48'h55;
    src_b     = 48'h01;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("rst_pre_valid", 48'(out_valid), 48'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 48'(out_valid), 48'd0);
    check("rst_mid_result", result, 48'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_no_ghost", 48'(out_valid), 48'd0);
    issue(3'b000, 48'h03, 48'h04, 1'b0, 6'b111111);
    check("post_rst_result", result, 48'h07);
    tick();
    check("post_rst_drained", 48'(out_valid), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
